// File: rtl/cache_pkg.sv
// Shared state encoding, default widths and helpers for the direct-mapped cache.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RESP  = 2'd2,
        ST_WRITE = 2'd3
    } state_t;

    localparam int ANCHO_DEF = 32;
    localparam int PROF_DEF  = 10;
    localparam int IDX_DEF   = 4;
    localparam int STAT_W    = 32;
    localparam int CNT_W     = 4;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/cache_line_array.sv
// Tag/valid/data registers, one word per line, with a combinational lookup port.
// Latency: lookup is combinational; updates land on the next clock edge.
// Backpressure: none, a write is applied whenever wr_en_i is high.
module cache_line_array
    import cache_pkg::*;
#(
    parameter int ANCHO = ANCHO_DEF,
    parameter int PROF  = PROF_DEF,
    parameter int IDX   = IDX_DEF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [PROF-1:0]  lk_addr_i,
    output logic             lk_hit_o,
    output logic [ANCHO-1:0] lk_dat_o,
    input  logic             wr_en_i,
    input  logic             wr_alloc_i,
    input  logic [PROF-1:0]  wr_addr_i,
    input  logic [ANCHO-1:0] wr_dat_i
);

    localparam int LINES = 2**IDX;
    localparam int TAG_W = PROF - IDX;

    logic [TAG_W-1:0] tag_q  [LINES];
    logic [TAG_W-1:0] tag_d  [LINES];
    logic [ANCHO-1:0] data_q [LINES];
    logic [ANCHO-1:0] data_d [LINES];
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;

    logic [IDX-1:0]   lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX-1:0]   wr_idx;
    logic [TAG_W-1:0] wr_tag;

    assign lk_idx = lk_addr_i[IDX-1:0];
    assign lk_tag = lk_addr_i[PROF-1:IDX];
    assign wr_idx = wr_addr_i[IDX-1:0];
    assign wr_tag = wr_addr_i[PROF-1:IDX];

    assign lk_hit_o = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign lk_dat_o = data_q[lk_idx];

    // Write-hit updates only the data word; a fill also claims tag and valid.
    always_comb begin
        tag_d   = tag_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (wr_en_i) begin
            data_d[wr_idx] = wr_dat_i;
            if (wr_alloc_i) begin
                tag_d[wr_idx]   = wr_tag;
                valid_d[wr_idx] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        tag_q  <= tag_d;
        data_q <= data_d;
        if (rst_i) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule

// File: rtl/cache_ctrl_dm.sv
// Direct-mapped write-through, no-write-allocate cache controller; hit/miss counters under CACHE_STATS_EN.
// Latency after accept: read hit 1, read miss MEM_LAT+2, write 1 cycle.
// Backpressure: CPU holds req_i until ready_o; requests are only accepted in IDLE.
module cache_ctrl_dm
    import cache_pkg::*;
#(
    parameter int ANCHO   = ANCHO_DEF,
    parameter int PROF    = PROF_DEF,
    parameter int IDX     = IDX_DEF,
    parameter int MEM_LAT = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [PROF-1:0]   addr_i,
    input  logic [ANCHO-1:0]  wdata_i,
    output logic [ANCHO-1:0]  rdata_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              mem_wren_o,
    output logic [PROF-1:0]   mem_wraddr_o,
    output logic [ANCHO-1:0]  mem_wrdata_o,
    output logic              mem_rden_o,
    output logic [PROF-1:0]   mem_rdaddr_o,
    input  logic [ANCHO-1:0]  mem_rddata_i,
    output logic [STAT_W-1:0] hit_cnt_o,
    output logic [STAT_W-1:0] miss_cnt_o
);

    localparam logic [CNT_W-1:0] LAT_C = CNT_W'(MEM_LAT);

    state_t           state_q, state_d;
    logic             we_q, we_d;
    logic             hit_q, hit_d;
    logic [PROF-1:0]  addr_q, addr_d;
    logic [ANCHO-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             accept;
    logic             fill_done;
    logic             lk_hit;
    logic [ANCHO-1:0] lk_dat;
    logic [PROF-1:0]  lk_addr;
    logic             arr_wr_en;
    logic [ANCHO-1:0] arr_wr_dat;

    assign accept     = (state_q == ST_IDLE) && req_i;
    assign fill_done  = (state_q == ST_FILL) && (cnt_q == LAT_C);
    // Hit is judged on the live address while idle; afterwards the latched one serves RESP.
    assign lk_addr    = (state_q == ST_IDLE) ? addr_i : addr_q;
    assign arr_wr_en  = fill_done || ((state_q == ST_WRITE) && hit_q);
    assign arr_wr_dat = fill_done ? mem_rddata_i : wdata_q;

    cache_line_array #(
        .ANCHO (ANCHO),
        .PROF  (PROF),
        .IDX   (IDX)
    ) u_lines (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .lk_addr_i  (lk_addr),
        .lk_hit_o   (lk_hit),
        .lk_dat_o   (lk_dat),
        .wr_en_i    (arr_wr_en),
        .wr_alloc_i (fill_done),
        .wr_addr_i  (addr_q),
        .wr_dat_i   (arr_wr_dat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            hit_q   <= hit_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        hit_d   = hit_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    addr_d  = addr_i;
                    wdata_d = wdata_i;
                    hit_d   = lk_hit;
                    cnt_d   = '0;
                    if (we_i) begin
                        state_d = ST_WRITE;
                    end else if (lk_hit) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_FILL;
                    end
                end
            end
            ST_FILL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAT_C) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_o      = 1'b0;
        rdata_o      = '0;
        busy_o       = (state_q != ST_IDLE);
        mem_wren_o   = 1'b0;
        mem_wraddr_o = '0;
        mem_wrdata_o = '0;
        mem_rden_o   = 1'b0;
        mem_rdaddr_o = '0;
        case (state_q)
            ST_FILL: begin
                mem_rden_o   = 1'b1;
                mem_rdaddr_o = addr_q;
            end
            ST_RESP: begin
                ready_o = 1'b1;
                rdata_o = lk_dat;
            end
            ST_WRITE: begin
                ready_o      = 1'b1;
                mem_wren_o   = 1'b1;
                mem_wraddr_o = addr_q;
                mem_wrdata_o = wdata_q;
            end
            default: ;
        endcase
    end

`ifdef CACHE_STATS_EN
    logic [STAT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [STAT_W-1:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (accept && lk_hit) begin
            hit_cnt_d = sat_inc(hit_cnt_q);
        end
        if (accept && !we_i && !lk_hit) begin
            miss_cnt_d = sat_inc(miss_cnt_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cache_ctrl_dm.sv
// Directed bench for cache_ctrl_dm with a MEM_LAT=1 registered-read memory model.
module tb_cache_ctrl_dm;

    localparam int ANCHO   = 32;
    localparam int PROF    = 10;
    localparam int IDX     = 4;
    localparam int MEM_LAT = 1;
`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic             req_i = 1'b0;
    logic             we_i = 1'b0;
    logic [PROF-1:0]  addr_i = '0;
    logic [ANCHO-1:0] wdata_i = '0;
    logic [ANCHO-1:0] rdata_o;
    logic             ready_o;
    logic             busy_o;
    logic             mem_wren_o;
    logic [PROF-1:0]  mem_wraddr_o;
    logic [ANCHO-1:0] mem_wrdata_o;
    logic             mem_rden_o;
    logic [PROF-1:0]  mem_rdaddr_o;
    logic [ANCHO-1:0] mem_rddata_i = '0;
    logic [31:0]      hit_cnt_o;
    logic [31:0]      miss_cnt_o;

    cache_ctrl_dm #(
        .ANCHO   (ANCHO),
        .PROF    (PROF),
        .IDX     (IDX),
        .MEM_LAT (MEM_LAT)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .req_i        (req_i),
        .we_i         (we_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .rdata_o      (rdata_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o),
        .mem_wren_o   (mem_wren_o),
        .mem_wraddr_o (mem_wraddr_o),
        .mem_wrdata_o (mem_wrdata_o),
        .mem_rden_o   (mem_rden_o),
        .mem_rdaddr_o (mem_rdaddr_o),
        .mem_rddata_i (mem_rddata_i),
        .hit_cnt_o    (hit_cnt_o),
        .miss_cnt_o   (miss_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    logic [ANCHO-1:0] mem [2**PROF];

    always @(posedge clk_i) begin
        if (mem_wren_o) mem[mem_wraddr_o] <= mem_wrdata_o;
        if (mem_rden_o) mem_rddata_i <= mem[mem_rdaddr_o];
    end

    int n_chk = 0;
    int n_pass = 0;
    int exp_hit = 0;
    int exp_miss = 0;
    int both_cyc = 0;

    int               lat, rd_cyc, wr_cyc;
    logic [PROF-1:0]  rd_a, wr_a;
    logic [ANCHO-1:0] wr_d, rdat;

    always @(negedge clk_i) begin
        if (mem_rden_o && mem_wren_o) both_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_cnt(input string tag);
        check({tag, "_hits"}, hit_cnt_o, STATS ? 32'(exp_hit) : 32'd0);
        check({tag, "_misses"}, miss_cnt_o, STATS ? 32'(exp_miss) : 32'd0);
    endtask

    // One request held until ready_o (bounded), recording memory-side activity; ends idle.
    task automatic do_req(input logic we, input logic [PROF-1:0] a, input logic [ANCHO-1:0] d);
        bit got;
        got = 1'b0;
        req_i = 1'b1; we_i = we; addr_i = a; wdata_i = d;
        lat = 0; rd_cyc = 0; wr_cyc = 0;
        rd_a = '0; wr_a = '0; wr_d = '0; rdat = '0;
        for (int c = 1; c <= 40 && !got; c++) begin
            @(negedge clk_i);
            if (mem_rden_o) begin rd_cyc++; rd_a = mem_rdaddr_o; end
            if (mem_wren_o) begin wr_cyc++; wr_a = mem_wraddr_o; wr_d = mem_wrdata_o; end
            if (ready_o) begin got = 1'b1; lat = c; rdat = rdata_o; end
        end
        req_i = 1'b0; we_i = 1'b0;
        @(negedge clk_i);
    endtask

    initial begin
        mem[10'h000] = 32'h007302B3;
        mem[10'h010] = 32'h0BAD0BAD;
        mem[10'h020] = 32'hCAFEF00D;

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_ready", 32'(ready_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_rden", 32'(mem_rden_o), 32'd0);
        check("rst_wren", 32'(mem_wren_o), 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check_cnt("rst");

        // Cold read miss on 0x000.
        do_req(1'b0, 10'h000, '0);
        exp_miss++;
        check("miss0_lat", 32'(lat), 32'd3);
        check("miss0_rdcyc", 32'(rd_cyc), 32'd2);
        check("miss0_rdaddr", 32'(rd_a), 32'h000);
        check("miss0_rdata", rdat, 32'h007302B3);
        check("miss0_wrcyc", 32'(wr_cyc), 32'd0);

        // Same address now hits.
        do_req(1'b0, 10'h000, '0);
        exp_hit++;
        check("hit0_lat", 32'(lat), 32'd1);
        check("hit0_rdcyc", 32'(rd_cyc), 32'd0);
        check("hit0_rdata", rdat, 32'h007302B3);
        check_cnt("hit0");

        // Write miss to aliasing line: goes to memory, no allocate.
        do_req(1'b1, 10'h010, 32'hDEADBEEF);
        check("wmiss_lat", 32'(lat), 32'd1);
        check("wmiss_wrcyc", 32'(wr_cyc), 32'd1);
        check("wmiss_wraddr", 32'(wr_a), 32'h010);
        check("wmiss_wrdata", wr_d, 32'hDEADBEEF);
        check("wmiss_rdcyc", 32'(rd_cyc), 32'd0);
        check("wmiss_mem", mem[10'h010], 32'hDEADBEEF);

        do_req(1'b0, 10'h010, '0);
        exp_miss++;
        check("miss10_lat", 32'(lat), 32'd3);
        check("miss10_rdaddr", 32'(rd_a), 32'h010);
        check("miss10_rdata", rdat, 32'hDEADBEEF);

        // Line 0 was evicted by 0x010.
        do_req(1'b0, 10'h000, '0);
        exp_miss++;
        check("evict0_lat", 32'(lat), 32'd3);
        check("evict0_rdata", rdat, 32'h007302B3);

        // Bring 0x010 back, then write-hit it.
        do_req(1'b0, 10'h010, '0);
        exp_miss++;
        check("refill10_lat", 32'(lat), 32'd3);
        do_req(1'b1, 10'h010, 32'h12345678);
        exp_hit++;
        check("whit_lat", 32'(lat), 32'd1);
        check("whit_wrdata", wr_d, 32'h12345678);
        check("whit_mem", mem[10'h010], 32'h12345678);
        do_req(1'b0, 10'h010, '0);
        exp_hit++;
        check("rhit10_lat", 32'(lat), 32'd1);
        check("rhit10_rdcyc", 32'(rd_cyc), 32'd0);
        check("rhit10_rdata", rdat, 32'h12345678);
        check_cnt("whit");

        // Request held through RESP: second accept only once back in IDLE.
        req_i = 1'b1; we_i = 1'b0; addr_i = 10'h010;
        @(negedge clk_i);
        exp_hit++;
        check("hold_ready1", 32'(ready_o), 32'd1);
        check("hold_rdata1", rdata_o, 32'h12345678);
        @(negedge clk_i);
        check("hold_gap_ready", 32'(ready_o), 32'd0);
        check("hold_gap_busy", 32'(busy_o), 32'd0);
        check("hold_gap_rdata", rdata_o, 32'd0);
        @(negedge clk_i);
        exp_hit++;
        check("hold_ready2", 32'(ready_o), 32'd1);
        check("hold_rdata2", rdata_o, 32'h12345678);
        req_i = 1'b0;
        @(negedge clk_i);
        check_cnt("hold");

        // Reset during the second FILL cycle of a read of 0x020.
        req_i = 1'b1; we_i = 1'b0; addr_i = 10'h020;
        @(negedge clk_i);
        check("rf_fill1_rden", 32'(mem_rden_o), 32'd1);
        @(negedge clk_i);
        check("rf_fill2_rden", 32'(mem_rden_o), 32'd1);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0; req_i = 1'b0;
        exp_hit = 0; exp_miss = 0;
        check("rf_rden", 32'(mem_rden_o), 32'd0);
        check("rf_ready", 32'(ready_o), 32'd0);
        check("rf_busy", 32'(busy_o), 32'd0);
        check_cnt("rf");
        @(negedge clk_i);

        do_req(1'b0, 10'h020, '0);
        exp_miss++;
        check("post_rst_lat", 32'(lat), 32'd3);
        check("post_rst_rdata", rdat, 32'hCAFEF00D);
        do_req(1'b0, 10'h010, '0);
        exp_miss++;
        check("post_rst_10_lat", 32'(lat), 32'd3);
        check("post_rst_10_rdata", rdat, 32'h12345678);
        check_cnt("post_rst");

        check("never_both_en", 32'(both_cyc), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cache_ctrl_dm.md
Name: cache_ctrl_dm

Overview:
Direct-mapped, write-through, no-write-allocate instruction/data cache controller for the single-cycle RISC-V core.
- CPU side: a request/ready handshake.
- Memory side: the initiator toward the dual-port word memory. It drives that memory's write port (wren/wraddr/wrdata) and read port (rden/rdaddr), and consumes its read data.
- One word per line. Tag, valid and data arrays are held in registers inside the block.

Parameters:
ANCHO, 32, data word width in bits
PROF, 10, word-address width (backing memory depth = 2**PROF words)
IDX, 4, line-index width; LINES = 2**IDX; tag width = PROF-IDX
MEM_LAT, 1, cycles the backing memory needs before mem_rddata_i is valid after mem_rden_o/mem_rdaddr_o are presented (0..15)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
req_i  in  1  CPU request; sampled only in IDLE
we_i  in  1  1 = write, 0 = read; sampled with req_i
addr_i  in  PROF  CPU word address
wdata_i  in  ANCHO  CPU write data
rdata_o  out  ANCHO  read data; valid while ready_o=1 for a read
ready_o  out  1  one-cycle completion pulse
busy_o  out  1  1 whenever state != IDLE
mem_wren_o  out  1  memory write enable
mem_wraddr_o  out  PROF  memory write address
mem_wrdata_o  out  ANCHO  memory write data
mem_rden_o  out  1  memory read enable
mem_rdaddr_o  out  PROF  memory read address
mem_rddata_i  in  ANCHO  memory read data
hit_cnt_o  out  32  hit count (CACHE_STATS_EN only; otherwise tied to 0)
miss_cnt_o  out  32  read-miss count (CACHE_STATS_EN only; otherwise tied to 0)

Behaviour:
- Reset (synchronous):
  - state=IDLE; all valid bits=0.
  - All outputs 0, including the counters.
  - Tag and data arrays are not reset.
- Address split: index = addr[IDX-1:0], tag = addr[PROF-1:IDX].
- IDLE:
  - If req_i=1, latch we_i, addr_i and wdata_i.
  - Hit = valid[index] and tag match, evaluated on addr_i in the accept cycle.
  - Transitions: write -> WRITE; read hit -> RESP; read miss -> FILL with the wait counter cleared.
  - req_i is ignored in every state except IDLE. The CPU holds the request until ready_o.
- FILL:
  - mem_rden_o=1 and mem_rdaddr_o = latched address, held constant for MEM_LAT+1 cycles.
  - The counter counts 0..MEM_LAT.
  - When counter==MEM_LAT: capture mem_rddata_i into data[index], write tag[index], set valid[index]=1, go to RESP.
- RESP:
  - ready_o=1 and rdata_o = data[latched index] for one cycle, then IDLE.
  - rdata_o is 0 outside RESP.
- WRITE:
  - mem_wren_o=1, mem_wraddr_o = latched address, mem_wrdata_o = latched data, all for exactly one cycle.
  - If the access was a hit at accept, data[index] is updated the same cycle. A miss does not allocate and leaves valid unchanged.
  - ready_o=1 in this same cycle, then IDLE.
- Latency from accept cycle to ready_o: read hit 1 cycle; read miss MEM_LAT+2 cycles; write 1 cycle.
- Throughput: minimum 2 cycles per request, because no request is accepted in RESP or WRITE.
- Memory-side signals are 0 in every state where they are not driven as listed above.
- mem_rden_o and mem_wren_o are never asserted in the same cycle.
- Conflicting addresses (same index, different tag): a read miss replaces the resident line. No write-back is needed (write-through).
- Reset mid-FILL or mid-WRITE: return to IDLE next cycle. No valid bit is set. Memory enables drop to 0 the cycle after rst_i is sampled.
- Index wrap: addresses 2**IDX apart alias to the same line.

Optional Feature:
CACHE_STATS_EN:
- Defined:
  - hit_cnt_o increments once per accepted hit (read or write).
  - miss_cnt_o increments once per accepted read miss.
  - Both saturate at 32'hFFFFFFFF and are cleared by reset.
- Undefined: both ports are constant 0 and no counter flops exist.

Decomposition:
- Shared package cache_pkg:
  - state encoding typedef (IDLE, FILL, RESP, WRITE)
  - default widths: ANCHO_DEF=32, PROF_DEF=10, IDX_DEF=4
  - STAT_W=32
- One natural sub-module: cache_line_array, holding the tag/valid/data registers.
  - Combinational lookup port: hit and data out.
  - Synchronous write port: fill or write-hit update.
  - Valid-clear on rst_i.
- The FSM stays in cache_ctrl_dm.

Test Plan:
- Reset, then read addr 0x000 with memory word 0 = 32'h007302B3 and MEM_LAT=1 -> mem_rden_o=1 for 2 cycles with rdaddr 0x000; ready_o at cycle 3 after accept; rdata_o=32'h007302B3.
- Repeat read 0x000 -> ready_o 1 cycle after accept; mem_rden_o stays 0; hit_cnt_o=1, miss_cnt_o=1.
- Write 0x010 with 32'hDEADBEEF (miss) -> one-cycle mem_wren_o with wraddr 0x010 and that data; ready_o the same cycle. A following read of 0x010 misses, fetches DEADBEEF, and evicts line 0. A read of 0x000 then misses again.
- Write-hit 0x010 with 32'h12345678 -> memory written; a following read of 0x010 hits and returns 32'h12345678 with no mem_rden_o.
- Assert rst_i during the second FILL cycle of a read of 0x020 -> next cycle state IDLE with mem_rden_o=0 and ready_o=0. A subsequent read of 0x020 misses.
- req_i held high through RESP -> no second accept until IDLE; a new request accepted in IDLE completes normally.
